// File: rtl/serial_bit_source.sv
// serial_bit_source
//   Parallel-to-serial stage feeding the single-bit input of the sequence
//   detectors. WIDTH-bit words arrive over a valid/ready handshake and are
//   shifted out one bit per clock on a registered output. Words offered back
//   to back form a gap-free bit stream, so patterns spanning word boundaries
//   reach the detector intact.
//
// Parameters
//   WIDTH     bits per word (>= 1)
//   MSB_FIRST 1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   IDLE_BIT  level driven on x while no word is being shifted
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   din        in   parallel word to serialize
//   din_valid  in   din holds a word to send
//   din_ready  out  word is taken on this edge (combinational)
//   x          out  serial bit (registered)
//   x_valid    out  x carries a data bit (registered)
//   last       out  x carries the final bit of the word (registered)
//   busy       out  a word is in flight
module serial_bit_source #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             last_q, last_d;
    logic             accept;

    // The bit that leaves next is always at the "front" end of the register;
    // which end that is depends on the transmit order.
    function automatic logic front_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_comb begin
        shifted = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end

    // Ready during the final bit lets the next word load with no idle gap.
    assign din_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
    assign accept    = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        xv_d    = xv_q;
        last_d  = last_q;

        if (accept) begin
            state_d = SHIFT;
            shreg_d = din;
            cnt_d   = CNT_LOAD;
            x_d     = front_bit(din);
            xv_d    = 1'b1;
            last_d  = (WIDTH == 1);
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                shreg_d = shifted;
                x_d     = front_bit(shifted);
                cnt_d   = cnt_q - CNT_ONE;
                last_d  = (cnt_q == CNT_ONE);
            end else begin
                state_d = IDLE;
                x_d     = IDLE_BIT;
                xv_d    = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            x_q     <= IDLE_BIT;
            xv_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            last_q  <= last_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign last    = last_q;
    assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_bit_source.sv
module tb_serial_bit_source;

    logic clk = 1'b0;
    logic rst;

    // WIDTH=8, MSB first
    logic [7:0]  din_m;
    logic        dv_m, rdy_m, x_m, xv_m, last_m, busy_m;
    // WIDTH=8, LSB first
    logic [7:0]  din_l;
    logic        dv_l, rdy_l, x_l, xv_l, last_l, busy_l;
    // WIDTH=11, MSB first, feeds the detector
    logic [10:0] din_w;
    logic        dv_w, rdy_w, x_w, xv_w, last_w, busy_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
        .x(x_m), .x_valid(xv_m), .last(last_m), .busy(busy_m));

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
        .x(x_l), .x_valid(xv_l), .last(last_l), .busy(busy_l));

    serial_bit_source #(.WIDTH(11), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w11 (
        .clk(clk), .rst(rst), .din(din_w), .din_valid(dv_w), .din_ready(rdy_w),
        .x(x_w), .x_valid(xv_w), .last(last_w), .busy(busy_w));

    // Downstream overlapping "101" detector: y is high once the last three
    // received bits are 1,0,1.
    logic [2:0] det_hist;
    int         det_n;
    logic       det_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_hist <= 3'b000;
            det_n    <= 0;
        end else if (xv_w) begin
            det_hist <= {det_hist[1:0], x_w};
            if (det_n < 3) det_n <= det_n + 1;
        end
    end

    assign det_y = (det_n >= 3) && (det_hist == 3'b101);

    task automatic test_reset();
        rst = 1'b1;
        dv_m = 1'b0; dv_l = 1'b0; dv_w = 1'b0;
        din_m = '0; din_l = '0; din_w = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_msb: got %b expected 00001", {x_m, xv_m, last_m, busy_m, rdy_m});
        end
        n_checks++;
        if ({x_l, xv_l, last_l, busy_l, rdy_l} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_lsb: got %b expected 00001", {x_l, xv_l, last_l, busy_l, rdy_l});
        end
        n_checks++;
        if ({x_w, xv_w, last_w, busy_w, rdy_w} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_w11: got %b expected 00001", {x_w, xv_w, last_w, busy_w, rdy_w});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [4:0] expv;
        w = 8'b0101_1001;
        @(negedge clk);
        din_m = w; dv_m = 1'b1;
        n_checks++;
        if (rdy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", rdy_m);
        end
        @(negedge clk);
        dv_m = 1'b0; din_m = '0;
        for (int i = 0; i < 8; i++) begin
            // {x, x_valid, last, busy, din_ready}
            expv = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
            n_checks++;
            if ({x_m, xv_m, last_m, busy_m, rdy_m} !== expv) begin
                n_fail++;
                $display("FAIL single_bit%0d: got %b expected %b", i, {x_m, xv_m, last_m, busy_m, rdy_m}, expv);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            n_fail++;
            $display("FAIL single_idle: got %b expected 00001", {x_m, xv_m, last_m, busy_m, rdy_m});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  w0, w1;
        logic [15:0] stream;
        logic        fin;
        logic [4:0]  expv;
        w0 = 8'hA5; w1 = 8'h3C;
        stream = {w0, w1};
        @(negedge clk);
        din_m = w0; dv_m = 1'b1;
        n_checks++;
        if (rdy_m !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready0: got %b expected 1", rdy_m);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) din_m = w1;
            if (c == 8) begin dv_m = 1'b0; din_m = '0; end
            fin = (c == 7) || (c == 15);
            expv = {stream[15-c], 1'b1, fin, 1'b1, fin};
            n_checks++;
            if ({x_m, xv_m, last_m, busy_m, rdy_m} !== expv) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got %b expected %b", c, {x_m, xv_m, last_m, busy_m, rdy_m}, expv);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b expected 00001", {x_m, xv_m, last_m, busy_m, rdy_m});
        end
    endtask

    task automatic test_stall();
        logic [7:0]  w0, w1;
        logic [15:0] stream;
        logic        fin;
        logic [4:0]  expv;
        w0 = 8'($urandom); w1 = 8'($urandom);
        stream = {w0, w1};
        @(negedge clk);
        din_m = w0; dv_m = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin dv_m = 1'b0; din_m = '0; end
            if (c == 1) begin dv_m = 1'b1; din_m = w1; end
            if (c == 8) begin dv_m = 1'b0; din_m = '0; end
            fin = (c == 7) || (c == 15);
            expv = {stream[15-c], 1'b1, fin, 1'b1, fin};
            n_checks++;
            if ({x_m, xv_m, last_m, busy_m, rdy_m} !== expv) begin
                n_fail++;
                $display("FAIL stall_bit%0d: got %b expected %b", c, {x_m, xv_m, last_m, busy_m, rdy_m}, expv);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({x_m, xv_m, last_m, busy_m} !== 4'b0000) begin
            n_fail++;
            $display("FAIL stall_idle: got %b expected 0000", {x_m, xv_m, last_m, busy_m});
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] w;
        logic [4:0] expv;
        @(negedge clk);
        din_m = 8'hFF; dv_m = 1'b1;
        @(negedge clk);
        dv_m = 1'b0; din_m = '0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({x_m, xv_m, busy_m} !== 3'b111) begin
                n_fail++;
                $display("FAIL areset_pre%0d: got %b expected 111", c, {x_m, xv_m, busy_m});
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({x_m, xv_m, last_m, busy_m, rdy_m} !== 5'b00001) begin
            n_fail++;
            $display("FAIL areset_async: got %b expected 00001", {x_m, xv_m, last_m, busy_m, rdy_m});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({x_m, xv_m, last_m, busy_m} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_after: got %b expected 0000", {x_m, xv_m, last_m, busy_m});
        end
        w = 8'h81;
        din_m = w; dv_m = 1'b1;
        @(negedge clk);
        dv_m = 1'b0; din_m = '0;
        for (int i = 0; i < 8; i++) begin
            expv = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
            n_checks++;
            if ({x_m, xv_m, last_m, busy_m, rdy_m} !== expv) begin
                n_fail++;
                $display("FAIL areset_bit%0d: got %b expected %b", i, {x_m, xv_m, last_m, busy_m, rdy_m}, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        logic [4:0] expv;
        w = 8'b0000_0110;
        @(negedge clk);
        din_l = w; dv_l = 1'b1;
        @(negedge clk);
        dv_l = 1'b0; din_l = '0;
        for (int i = 0; i < 8; i++) begin
            expv = {w[i], 1'b1, (i == 7), 1'b1, (i == 7)};
            n_checks++;
            if ({x_l, xv_l, last_l, busy_l, rdy_l} !== expv) begin
                n_fail++;
                $display("FAIL lsb_bit%0d: got %b expected %b", i, {x_l, xv_l, last_l, busy_l, rdy_l}, expv);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({x_l, xv_l, last_l, busy_l} !== 4'b0000) begin
            n_fail++;
            $display("FAIL lsb_idle: got %b expected 0000", {x_l, xv_l, last_l, busy_l});
        end
    endtask

    task automatic test_detector_feed();
        logic [10:0] w;
        logic [10:0] y_gold;
        logic [3:0]  expv;
        w      = 11'b010_1001_0111;
        y_gold = 11'b000_1000_0100;
        @(negedge clk);
        din_w = w; dv_w = 1'b1;
        @(negedge clk);
        dv_w = 1'b0; din_w = '0;
        for (int i = 0; i < 11; i++) begin
            expv = {w[10-i], 1'b1, (i == 10), 1'b1};
            n_checks++;
            if ({x_w, xv_w, last_w, busy_w} !== expv) begin
                n_fail++;
                $display("FAIL w11_bit%0d: got %b expected %b", i, {x_w, xv_w, last_w, busy_w}, expv);
            end
            if (i > 0) begin
                n_checks++;
                if (det_y !== y_gold[11-i]) begin
                    n_fail++;
                    $display("FAIL det_y%0d: got %b expected %b", i - 1, det_y, y_gold[11-i]);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (det_y !== y_gold[0]) begin
            n_fail++;
            $display("FAIL det_y10: got %b expected %b", det_y, y_gold[0]);
        end
        n_checks++;
        if ({x_w, xv_w, last_w, busy_w} !== 4'b0000) begin
            n_fail++;
            $display("FAIL w11_idle: got %b expected 0000", {x_w, xv_w, last_w, busy_w});
        end
    endtask

    // Reference: a queue of the bits still to appear on x, front = bit now
    // on x. A word is taken when valid and at most one bit remains.
    task automatic test_random();
        bit         mq[$];
        bit         pending;
        logic [7:0] pend_word;
        logic       e_rdy, acc;
        logic [4:0] expv;
        pending = 1'b0;
        pend_word = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            e_rdy = (mq.size() <= 1);
            expv = {(mq.size() > 0) ? logic'(mq[0]) : 1'b0, (mq.size() > 0),
                    (mq.size() == 1), (mq.size() > 0), e_rdy};
            n_checks++;
            if ({x_m, xv_m, last_m, busy_m, rdy_m} !== expv) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %b expected %b", cyc, {x_m, xv_m, last_m, busy_m, rdy_m}, expv);
            end
            if (!pending && ($urandom_range(0, 3) != 0)) begin
                pending = 1'b1;
                pend_word = 8'($urandom);
            end
            dv_m  = pending;
            din_m = pending ? pend_word : 8'($urandom);
            @(posedge clk);
            acc = dv_m && e_rdy;
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                for (int b = 7; b >= 0; b--) mq.push_back(pend_word[b]);
                pending = 1'b0;
            end
        end
        @(negedge clk);
        dv_m = 1'b0; din_m = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_detector_feed();
        test_random();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
